bullet_pool: RTL and testbench

Multi-bullet projectile engine for the Tank 1990 playfield, replacing the single hard-wired bullet inside the tank controller. It holds NUM_BULLETS independent slots and spawns from the tank's position and one-hot direction, subject to a fire cooldown. Each frame it advances every live bullet, retires bullets that leave the playfield, and retires bullets that strike a brick. Brick hits are reported as a one-frame event so the brick-map owner can clear the cell.

---
 rtl/bullet_pool.sv | 164 ++++++++++++++++
 tb/tb_bullet_pool.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_pool.sv
// Multi-slot projectile engine: spawns bullets from the tank, advances them once per
// frame, retires them on leaving the playfield or on a brick strike (one hit reported per frame).
module bullet_pool #(
    parameter int NUM_BULLETS = 4,
    parameter int SPEED       = 2,
    parameter int COOLDOWN    = 8,
    parameter int X_MIN       = 80,
    parameter int X_MAX       = 559,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 479
) (
    input  logic                         frame_clk,
    input  logic                         Reset,
    input  logic                         fire,
    input  logic [9:0]                   TankX,
    input  logic [9:0]                   TankY,
    input  logic [3:0]                   TankDir,
    input  logic [29:0][39:0]            brick_map,
    output logic [NUM_BULLETS-1:0]       bullet_active,
    output logic [NUM_BULLETS-1:0][9:0]  bullet_x,
    output logic [NUM_BULLETS-1:0][9:0]  bullet_y,
    output logic [NUM_BULLETS-1:0][3:0]  bullet_dir,
    output logic                         hit_valid,
    output logic [4:0]                   hit_row,
    output logic [5:0]                   hit_col,
    output logic [3:0]                   active_count
);

    localparam int IW = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
    localparam int CW = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
    localparam logic [9:0] SPD = 10'(SPEED);

    logic [CW-1:0]                cooldown, cooldown_n;
    logic [NUM_BULLETS-1:0]       act_n;
    logic [NUM_BULLETS-1:0][9:0]  x_n, y_n;
    logic [NUM_BULLETS-1:0][3:0]  dir_n;
    logic                         hv_n;
    logic [4:0]                   hr_n;
    logic [5:0]                   hc_n;
    logic [3:0]                   count_n;
    logic                         free_found;
    logic [IW-1:0]                free_idx;
    logic                         dir_ok;
    logic                         shot;
    logic                         hit_taken;
    logic [9:0]                   tx, ty, px, py;
    logic                         in_pf;
    logic                         brick;

    always_comb begin
        act_n      = bullet_active;
        x_n        = bullet_x;
        y_n        = bullet_y;
        dir_n      = bullet_dir;
        hv_n       = 1'b0;
        hr_n       = hit_row;
        hc_n       = hit_col;
        count_n    = '0;
        hit_taken  = 1'b0;
        free_found = 1'b0;
        free_idx   = '0;
        tx         = '0;
        ty         = '0;
        px         = '0;
        py         = '0;
        in_pf      = 1'b0;
        brick      = 1'b0;

        for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
            if (!bullet_active[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end

        dir_ok = (TankDir == 4'b0001) || (TankDir == 4'b0010) ||
                 (TankDir == 4'b0100) || (TankDir == 4'b1000);
        shot   = fire && (cooldown == '0) && free_found && dir_ok;

        // Slot scan runs low to high so the first brick candidate wins the hit report.
        for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
            tx = bullet_x[i];
            ty = bullet_y[i];
            px = bullet_x[i] + 10'd4;
            py = bullet_y[i] + 10'd4;
            case (bullet_dir[i])
                4'b0001: begin ty = bullet_y[i] - SPD; px = tx + 10'd4; py = ty;          end
                4'b0010: begin ty = bullet_y[i] + SPD; px = tx + 10'd4; py = ty + 10'd7;  end
                4'b0100: begin tx = bullet_x[i] - SPD; px = tx;         py = ty + 10'd4;  end
                4'b1000: begin tx = bullet_x[i] + SPD; px = tx + 10'd7; py = ty + 10'd4;  end
                default: ;
            endcase
            // +1 on the lower bound keeps the test meaningful when an edge parameter is 0.
            in_pf = (({1'b0, px} + 11'd1) > 11'(X_MIN)) && (px <= 10'(X_MAX)) &&
                    (({1'b0, py} + 11'd1) > 11'(Y_MIN)) && (py <= 10'(Y_MAX));
            brick = in_pf && brick_map[py[8:4]][6'd39 - px[9:4]];

            if (bullet_active[i]) begin
                if (!in_pf) begin
                    act_n[i] = 1'b0;
                end else if (brick) begin
                    if (!hit_taken) begin
                        hit_taken = 1'b1;
                        act_n[i]  = 1'b0;
                        hv_n      = 1'b1;
                        hr_n      = py[8:4];
                        hc_n      = px[9:4];
                    end
                end else begin
                    x_n[i] = tx;
                    y_n[i] = ty;
                end
            end else if (shot && (free_idx == IW'(i))) begin
                act_n[i] = 1'b1;
                dir_n[i] = TankDir;
                case (TankDir)
                    4'b0001: begin x_n[i] = TankX + 10'd12; y_n[i] = TankY - 10'd8;  end
                    4'b0010: begin x_n[i] = TankX + 10'd12; y_n[i] = TankY + 10'd32; end
                    4'b0100: begin x_n[i] = TankX - 10'd8;  y_n[i] = TankY + 10'd12; end
                    default: begin x_n[i] = TankX + 10'd32; y_n[i] = TankY + 10'd12; end
                endcase
            end
        end

        for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
            count_n = count_n + {3'b000, act_n[i]};
        end

        if (shot) begin
            cooldown_n = CW'(COOLDOWN);
        end else if (cooldown != '0) begin
            cooldown_n = cooldown - 1'b1;
        end else begin
            cooldown_n = cooldown;
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            bullet_active <= '0;
            bullet_x      <= '0;
            bullet_y      <= '0;
            for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
                bullet_dir[i] <= 4'b0001;
            end
            hit_valid     <= 1'b0;
            hit_row       <= '0;
            hit_col       <= '0;
            active_count  <= '0;
            cooldown      <= '0;
        end else begin
            bullet_active <= act_n;
            bullet_x      <= x_n;
            bullet_y      <= y_n;
            bullet_dir    <= dir_n;
            hit_valid     <= hv_n;
            hit_row       <= hr_n;
            hit_col       <= hc_n;
            active_count  <= count_n;
            cooldown      <= cooldown_n;
        end
    end

endmodule

// File: tb/tb_bullet_pool.sv
// Self-checking bench for bullet_pool: directed scenarios plus randomized frames,
// all compared against a frame-level reference model.
module tb_bullet_pool;

    localparam int NB     = 4;
    localparam int SPEED  = 2;
    localparam int CD     = 8;
    localparam int XMIN   = 80;
    localparam int XMAX   = 559;
    localparam int YMIN   = 0;
    localparam int YMAX   = 479;

    logic                 frame_clk = 1'b0;
    logic                 Reset;
    logic                 fire;
    logic [9:0]           TankX, TankY;
    logic [3:0]           TankDir;
    logic [29:0][39:0]    brick_map;
    logic [NB-1:0]        bullet_active;
    logic [NB-1:0][9:0]   bullet_x, bullet_y;
    logic [NB-1:0][3:0]   bullet_dir;
    logic                 hit_valid;
    logic [4:0]           hit_row;
    logic [5:0]           hit_col;
    logic [3:0]           active_count;

    bullet_pool #(
        .NUM_BULLETS(NB), .SPEED(SPEED), .COOLDOWN(CD),
        .X_MIN(XMIN), .X_MAX(XMAX), .Y_MIN(YMIN), .Y_MAX(YMAX)
    ) dut (
        .frame_clk(frame_clk), .Reset(Reset), .fire(fire),
        .TankX(TankX), .TankY(TankY), .TankDir(TankDir), .brick_map(brick_map),
        .bullet_active(bullet_active), .bullet_x(bullet_x), .bullet_y(bullet_y),
        .bullet_dir(bullet_dir), .hit_valid(hit_valid), .hit_row(hit_row),
        .hit_col(hit_col), .active_count(active_count)
    );

    always #5 frame_clk = ~frame_clk;

    int checks   = 0;
    int failures = 0;

    // Reference state: one entry per slot, plain integers.
    int m_act[NB], m_x[NB], m_y[NB], m_dir[NB];
    int m_cd, m_hv, m_hr, m_hc;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        int fidx, nx, ny, px, py;
        bit onehot, shot, hit_done;
        if (Reset) begin
            for (int i = 0; i < NB; i++) begin
                m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_dir[i] = 1;
            end
            m_cd = 0; m_hv = 0; m_hr = 0; m_hc = 0;
            return;
        end
        fidx = -1;
        for (int i = 0; i < NB; i++)
            if (m_act[i] == 0 && fidx < 0) fidx = i;
        onehot   = (TankDir == 1) || (TankDir == 2) || (TankDir == 4) || (TankDir == 8);
        shot     = fire && (m_cd == 0) && onehot && (fidx >= 0);
        hit_done = 0;
        m_hv     = 0;
        for (int i = 0; i < NB; i++) begin
            if (m_act[i] != 0) begin
                nx = m_x[i]; ny = m_y[i]; px = 0; py = 0;
                case (m_dir[i])
                    1: begin ny = (m_y[i] - SPEED) & 1023; px = nx + 4; py = ny;     end
                    2: begin ny = m_y[i] + SPEED;          px = nx + 4; py = ny + 7; end
                    4: begin nx = (m_x[i] - SPEED) & 1023; px = nx;     py = ny + 4; end
                    default: begin nx = m_x[i] + SPEED;    px = nx + 7; py = ny + 4; end
                endcase
                if (px < XMIN || px > XMAX || py < YMIN || py > YMAX) begin
                    m_act[i] = 0;
                end else if (brick_map[py / 16][39 - px / 16]) begin
                    if (!hit_done) begin
                        hit_done = 1; m_act[i] = 0;
                        m_hv = 1; m_hr = py / 16; m_hc = px / 16;
                    end
                end else begin
                    m_x[i] = nx; m_y[i] = ny;
                end
            end
        end
        if (shot) begin
            m_act[fidx] = 1;
            m_dir[fidx] = int'(TankDir);
            case (TankDir)
                4'b0001: begin m_x[fidx] = (int'(TankX) + 12) & 1023; m_y[fidx] = (int'(TankY) - 8) & 1023;  end
                4'b0010: begin m_x[fidx] = (int'(TankX) + 12) & 1023; m_y[fidx] = (int'(TankY) + 32) & 1023; end
                4'b0100: begin m_x[fidx] = (int'(TankX) - 8) & 1023;  m_y[fidx] = (int'(TankY) + 12) & 1023; end
                default: begin m_x[fidx] = (int'(TankX) + 32) & 1023; m_y[fidx] = (int'(TankY) + 12) & 1023; end
            endcase
        end
        m_cd = shot ? CD : ((m_cd > 0) ? m_cd - 1 : 0);
    endtask

    task automatic compare_all();
        int ev, cnt;
        ev = 0; cnt = 0;
        for (int i = 0; i < NB; i++) begin
            if (m_act[i] != 0) begin ev |= (1 << i); cnt++; end
            check($sformatf("x%0d", i),   int'(bullet_x[i]),   m_x[i]);
            check($sformatf("y%0d", i),   int'(bullet_y[i]),   m_y[i]);
            check($sformatf("dir%0d", i), int'(bullet_dir[i]), m_dir[i]);
        end
        check("active",    int'(bullet_active), ev);
        check("count",     int'(active_count),  cnt);
        check("hit_valid", int'(hit_valid),     m_hv);
        check("hit_row",   int'(hit_row),       m_hr);
        check("hit_col",   int'(hit_col),       m_hc);
    endtask

    task automatic step();
        @(posedge frame_clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        Reset = 1'b1; fire = 1'b0;
        step();
        Reset = 1'b0;
    endtask

    initial begin
        int guard;
        Reset = 1'b1; fire = 1'b0; TankX = 10'd320; TankY = 10'd240;
        TankDir = 4'b0001; brick_map = '0;
        for (int i = 0; i < NB; i++) begin
            m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_dir[i] = 1;
        end
        m_cd = 0; m_hv = 0; m_hr = 0; m_hc = 0;

        // Reset and spawn
        step();
        check("rst_active", int'(bullet_active), 0);
        check("rst_dir0",   int'(bullet_dir[0]), 1);
        Reset = 1'b0; fire = 1'b1;
        step();
        check("spawn_x",   int'(bullet_x[0]),   332);
        check("spawn_y",   int'(bullet_y[0]),   232);
        check("spawn_cnt", int'(active_count),  1);
        fire = 1'b0;
        repeat (10) step();
        check("fly_y", int'(bullet_y[0]), 212);

        // Brick hit
        do_reset();
        brick_map[10][19] = 1'b1;
        TankX = 10'd316; TankY = 10'd200; TankDir = 4'b0001; fire = 1'b1;
        step();
        fire = 1'b0;
        check("bh_spawn_y", int'(bullet_y[0]), 192);
        repeat (8) step();
        check("bh_pre_y",  int'(bullet_y[0]), 176);
        check("bh_pre_hv", int'(hit_valid),   0);
        step();
        check("bh_hv",   int'(hit_valid),        1);
        check("bh_row",  int'(hit_row),          10);
        check("bh_col",  int'(hit_col),          20);
        check("bh_act0", int'(bullet_active[0]), 0);
        check("bh_y",    int'(bullet_y[0]),      176);
        step();
        check("bh_pulse", int'(hit_valid), 0);

        // Off-playfield
        do_reset();
        brick_map = '0;
        TankX = 10'd80; TankY = 10'd240; TankDir = 4'b0100; fire = 1'b1;
        step();
        fire = 1'b0;
        check("off_x", int'(bullet_x[0]), 72);
        check("off_y", int'(bullet_y[0]), 252);
        step();
        check("off_act", int'(bullet_active[0]), 0);
        check("off_hv",  int'(hit_valid),        0);

        // Cooldown and full pool
        do_reset();
        TankX = 10'd320; TankY = 10'd240; TankDir = 4'b0001; fire = 1'b1;
        for (int f = 0; f <= 36; f++) begin
            step();
            check($sformatf("cd_cnt_f%0d", f), int'(active_count), (f / 9 + 1 > 4) ? 4 : f / 9 + 1);
        end
        for (int f = 37; f <= 130; f++) step();
        check("refill_cnt", int'(active_count), 4);
        check("refill_y0",  int'(bullet_y[0]),  208);

        // Simultaneous hits
        fire = 1'b0;
        do_reset();
        brick_map[5][39-10] = 1'b1;
        brick_map[5][39-30] = 1'b1;
        TankX = 10'd148; TankY = 10'd208; TankDir = 4'b0001; fire = 1'b1;
        step();
        fire = 1'b0;
        repeat (8) step();
        TankX = 10'd468; TankY = 10'd190; fire = 1'b1;
        step();
        fire = 1'b0;
        check("sim_y0", int'(bullet_y[0]), 182);
        check("sim_y1", int'(bullet_y[1]), 182);
        guard = 0;
        while (!hit_valid && guard < 60) begin
            step();
            guard++;
        end
        check("sim_hit_seen", int'(hit_valid),     1);
        check("sim_row1",     int'(hit_row),       5);
        check("sim_col1",     int'(hit_col),       10);
        check("sim_act1",     int'(bullet_active), 2);
        check("sim_held_y1",  int'(bullet_y[1]),   96);
        step();
        check("sim_hv2",  int'(hit_valid),     1);
        check("sim_row2", int'(hit_row),       5);
        check("sim_col2", int'(hit_col),       30);
        check("sim_act2", int'(bullet_active), 0);

        // Invalid direction and mid-flight reset
        do_reset();
        brick_map = '0;
        TankX = 10'd320; TankY = 10'd240; TankDir = 4'b0011; fire = 1'b1;
        step();
        check("bad_dir_cnt", int'(active_count), 0);
        TankDir = 4'b0001;
        step();
        check("after_bad_cnt", int'(active_count), 1);
        repeat (18) step();
        check("three_live", int'(active_count), 3);
        Reset = 1'b1; fire = 1'b0;
        step();
        Reset = 1'b0;
        check("mid_rst_act", int'(bullet_active), 0);
        check("mid_rst_hv",  int'(hit_valid),     0);

        // Randomized frames
        for (int n = 0; n < 2000; n++) begin
            if (n % 50 == 0) begin
                for (int r = 0; r < 30; r++)
                    brick_map[r] = 40'({$urandom, $urandom}) & 40'({$urandom, $urandom}) &
                                   40'({$urandom, $urandom});
            end
            Reset   = ($urandom % 200 == 0);
            fire    = ($urandom % 3 != 0);
            TankDir = ($urandom % 8 == 0) ? 4'($urandom % 16) : 4'(1 << ($urandom % 4));
            TankX   = 10'($urandom_range(60, 560));
            TankY   = 10'($urandom_range(0, 470));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
